fetch_unit: RTL and testbench

Instruction-fetch stage of the RISC-V pipelined processor. Owns the program counter and drives the address of the synchronous, byte-addressed, big-endian instruction memory. Re-times the memory's one-cycle-late read data against the PC that produced it. Presents an IF/ID-registered {pc, pc+4, instruction, valid} bundle to decode, with stall from the hazard unit and redirect from the branch/jump resolution in EX.

---
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the pipelined RISC-V core.
// Owns the program counter, drives the synchronous instruction memory and
// presents a registered {pc, pc+4, instruction, valid} bundle to decode.
// The memory returns data one cycle after the address, so the stage keeps
// the address of the word currently on imem_rdata (resp_pc) and a one-entry
// skid buffer that preserves that word while decode is stalled.

module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   input  logic [31:0] imem_rdata,
   output logic [31:0] imem_addr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic [31:0] id_instr,
   output logic        id_valid
);

   // Address currently presented to the instruction memory.
   logic [31:0] pc;

   // Address and validity of the word arriving on imem_rdata this cycle.
   logic [31:0] resp_pc;
   logic        resp_valid;

   // Skid buffer: keeps the stalled instruction once the memory has moved on.
   logic [31:0] hold_instr;
   logic        hold_valid;

   // Redirect targets are forced onto a word boundary.
   logic [31:0] target_aligned;

   // Sequential pc, next sequential pc and aligned redirect target.
   logic [31:0] pc_next_seq;

   assign target_aligned = redirect_target & ~32'h0000_0003;
   assign pc_next_seq    = pc + 32'd4;

   // Program counter: redirect beats stall, stall freezes, otherwise step by one word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= target_aligned;
      end else if (!stall) begin
         pc <= pc_next_seq;
      end
   end

   // Response tracking: the word on imem_rdata next cycle belongs to today's pc,
   // except after a redirect, where the in-flight word is from the wrong path.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_pc    <= RESET_PC;
         resp_valid <= 1'b0;
      end else if (redirect) begin
         resp_pc    <= target_aligned;
         resp_valid <= 1'b0;
      end else if (!stall) begin
         resp_pc    <= pc;
         resp_valid <= 1'b1;
      end
   end

   // Skid buffer: grab the instruction on the first stalled edge, because from
   // then on the memory is returning the word at resp_pc+4 instead.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_instr <= 32'h0000_0000;
         hold_valid <= 1'b0;
      end else if (redirect) begin
         hold_valid <= 1'b0;
      end else if (stall) begin
         if (!hold_valid) begin
            hold_instr <= imem_rdata;
            hold_valid <= 1'b1;
         end
      end else begin
         hold_valid <= 1'b0;
      end
   end

   // Decode-side bundle: bubbles show a NOP, stalled cycles show the held word.
   always_comb begin
      imem_addr   = pc;
      id_pc       = resp_pc;
      id_pc_plus4 = resp_pc + 32'd4;
      id_valid    = resp_valid;
      id_instr    = NOP_INSTR;
      if (resp_valid) begin
         id_instr = hold_valid ? hold_instr : imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// Models the synchronous big-endian instruction memory, replays a directed
// vector table (reset release, stall, redirect, stall in the bubble, reset
// mid-stall) and then a randomized run checked against an architectural
// model that tracks only "next address to fetch" and "what decode shows".

module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] imem_rdata;
   logic [31:0] imem_addr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [31:0] id_instr;
   logic        id_valid;

   int checkCount;
   int passCount;

   logic [7:0] memBytes [256];

   fetch_unit dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_rdata      (imem_rdata),
      .imem_addr       (imem_addr),
      .id_pc           (id_pc),
      .id_pc_plus4     (id_pc_plus4),
      .id_instr        (id_instr),
      .id_valid        (id_valid)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word at any byte address: image bytes in the low 256 bytes, a pattern elsewhere.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a < 32'd256)
         return {memBytes[a[7:0]], memBytes[a[7:0] + 8'd1],
                 memBytes[a[7:0] + 8'd2], memBytes[a[7:0] + 8'd3]};
      return ~a;
   endfunction

   // Synchronous instruction memory, reset held while fetch_unit is in reset.
   always @(posedge clk or posedge reset) begin
      if (reset) imem_rdata <= 32'h0000_0000;
      else       imem_rdata <= memWord(imem_addr);
   end

   task automatic putWord(input int a, input logic [31:0] w);
      memBytes[a]     = w[31:24];
      memBytes[a + 1] = w[23:16];
      memBytes[a + 2] = w[15:8];
      memBytes[a + 3] = w[7:0];
   endtask

   // Drive inputs for one cycle, then move to #1 after the active edge.
   task automatic applyStimulus(input logic r, input logic s, input logic [31:0] t);
      redirect        = r;
      stall           = s;
      redirect_target = t;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] ePc,
                              input logic [31:0] eInstr, input logic eValid,
                              input logic [31:0] eAddr);
      checkCount++;
      if (id_pc === ePc && id_pc_plus4 === ePc + 32'd4 && id_instr === eInstr &&
          id_valid === eValid && imem_addr === eAddr) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got pc=%h pc4=%h instr=%h valid=%b addr=%h, expected pc=%h pc4=%h instr=%h valid=%b addr=%h",
                  name, id_pc, id_pc_plus4, id_instr, id_valid, imem_addr,
                  ePc, ePc + 32'd4, eInstr, eValid, eAddr);
      end
   endtask

   typedef struct {
      logic        r;
      logic        s;
      logic [31:0] t;
      logic [31:0] ePc;
      logic [31:0] eInstr;
      logic        eValid;
      logic [31:0] eAddr;
   } vec_t;

   vec_t vecs [15];

   logic [31:0] nextFetch;
   logic [31:0] shownPc;
   logic        shownValid;

   initial begin
      logic        rr;
      logic        rs;
      logic [31:0] rt;

      checkCount = 0;
      passCount  = 0;
      for (int i = 0; i < 256; i++) memBytes[i] = 8'h00;
      putWord(32'h00, 32'h0000_0000);
      putWord(32'h04, 32'h00F0_0093);
      putWord(32'h08, 32'h03A0_4113);
      putWord(32'h0C, 32'h001C_C637);
      putWord(32'h10, 32'h0023_A797);
      putWord(32'h28, 32'h0280_8CE7);

      //            redir stall target        pc      instr          valid addr
      vecs[0]  = '{1'b0, 1'b0, 32'h0,  32'h00, 32'h0000_0000, 1'b1, 32'h04};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,  32'h04, 32'h00F0_0093, 1'b1, 32'h08};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,  32'h08, 32'h03A0_4113, 1'b1, 32'h0C};
      vecs[3]  = '{1'b0, 1'b1, 32'h0,  32'h08, 32'h03A0_4113, 1'b1, 32'h0C};
      vecs[4]  = '{1'b0, 1'b1, 32'h0,  32'h08, 32'h03A0_4113, 1'b1, 32'h0C};
      vecs[5]  = '{1'b0, 1'b1, 32'h0,  32'h08, 32'h03A0_4113, 1'b1, 32'h0C};
      vecs[6]  = '{1'b0, 1'b0, 32'h0,  32'h0C, 32'h001C_C637, 1'b1, 32'h10};
      vecs[7]  = '{1'b1, 1'b0, 32'h28, 32'h28, NOP,           1'b0, 32'h28};
      vecs[8]  = '{1'b0, 1'b0, 32'h0,  32'h28, 32'h0280_8CE7, 1'b1, 32'h2C};
      vecs[9]  = '{1'b1, 1'b1, 32'h2A, 32'h28, NOP,           1'b0, 32'h28};
      vecs[10] = '{1'b0, 1'b1, 32'h0,  32'h28, NOP,           1'b0, 32'h28};
      vecs[11] = '{1'b0, 1'b1, 32'h0,  32'h28, NOP,           1'b0, 32'h28};
      vecs[12] = '{1'b0, 1'b0, 32'h0,  32'h28, 32'h0280_8CE7, 1'b1, 32'h2C};
      vecs[13] = '{1'b0, 1'b0, 32'h0,  32'h2C, 32'h0000_0000, 1'b1, 32'h30};
      vecs[14] = '{1'b0, 1'b1, 32'h0,  32'h2C, 32'h0000_0000, 1'b1, 32'h30};

      reset           = 1'b1;
      stall           = 1'b0;
      redirect        = 1'b0;
      redirect_target = 32'h0;
      #1;
      checkOutput("reset_async", 32'h0, NOP, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_held", 32'h0, NOP, 1'b0, 32'h0);
      #1 reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].r, vecs[i].s, vecs[i].t);
         checkOutput($sformatf("vec%0d", i), vecs[i].ePc, vecs[i].eInstr,
                     vecs[i].eValid, vecs[i].eAddr);
      end

      // Reset arrives between edges while the stall is still asserted.
      #2 reset = 1'b1;
      #1;
      checkOutput("reset_mid_stall", 32'h0, NOP, 1'b0, 32'h0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(vecs[i].r, vecs[i].s, vecs[i].t);
         checkOutput($sformatf("restart%0d", i), vecs[i].ePc, vecs[i].eInstr,
                     vecs[i].eValid, vecs[i].eAddr);
      end

      // Randomized run from a clean reset against the architectural model.
      reset = 1'b1;
      #3 reset = 1'b0;
      nextFetch  = 32'h0;
      shownPc    = 32'h0;
      shownValid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         rr = ($urandom_range(0, 99) < 15);
         rs = ($urandom_range(0, 99) < 30);
         if ($urandom_range(0, 9) == 0)
            rt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
         else
            rt = $urandom_range(0, 255);
         applyStimulus(rr, rs, rt);
         if (rr) begin
            nextFetch  = {rt[31:2], 2'b00};
            shownPc    = nextFetch;
            shownValid = 1'b0;
         end else if (!rs) begin
            shownPc    = nextFetch;
            shownValid = 1'b1;
            nextFetch  = nextFetch + 32'd4;
         end
         checkOutput($sformatf("rand%0d", c), shownPc,
                     shownValid ? memWord(shownPc) : NOP, shownValid, nextFetch);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
